// File: rtl/score_display_sequencer_if.sv
// Handshake and display bus between the game logic, the score sequencer and
// the seven-segment scanner.
interface score_display_sequencer_if #(
  parameter int unsigned SCORE_W = 14
);
  logic [SCORE_W-1:0] Score;
  logic               ScoreValid;
  logic               GameOver;
  logic               GameStart;
  logic               DispEn;
  logic [3:0]         FirstDigit;
  logic [3:0]         SecondDigit;
  logic [3:0]         ThirdDigit;
  logic [3:0]         FourthDigit;
  logic               SegEn;
  logic               Busy;
  logic [SCORE_W-1:0] HighScore;

  modport master (
    output Score, ScoreValid, GameOver, GameStart, DispEn,
    input  FirstDigit, SecondDigit, ThirdDigit, FourthDigit, SegEn, Busy, HighScore
  );

  modport slave (
    input  Score, ScoreValid, GameOver, GameStart, DispEn,
    output FirstDigit, SecondDigit, ThirdDigit, FourthDigit, SegEn, Busy, HighScore
  );
endinterface

// File: rtl/score_display_sequencer.sv
// Chooses what the four-digit display shows: live score while playing, then a
// HIGH / high-score / last-score rotation after game over.
module score_display_sequencer #(
  parameter int unsigned SCORE_W      = 14,
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000,
  parameter logic [3:0]  LETTER_H     = 4'hA,
  parameter logic [3:0]  LETTER_I     = 4'hB,
  parameter logic [3:0]  LETTER_G     = 4'hC
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  score_display_sequencer_if.slave bus
);

  localparam int unsigned BCD_W     = 16;
  localparam int unsigned MAX_SCORE = 9999;
  localparam int unsigned CNT_W     = $clog2(SCORE_W + 1);
  localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned BLINK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [1:0] {
    PG_LIVE,
    PG_BANNER,
    PG_HISCORE,
    PG_LAST
  } page_e;

  page_e                state_q, state_n;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_n;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_n;
  logic                 blink_q, blink_n;

  logic                 conv_active_q, conv_active_n;
  logic [CNT_W-1:0]     conv_cnt_q, conv_cnt_n;
  logic [SCORE_W-1:0]   conv_bin_q, conv_bin_n;
  logic [BCD_W-1:0]     conv_bcd_q, conv_bcd_n;
  logic [SCORE_W-1:0]   conv_val_q, conv_val_n;
  logic                 pend_valid_q, pend_valid_n;
  logic [SCORE_W-1:0]   pend_val_q, pend_val_n;

  logic                 go_pend_q, go_pend_n;
  logic                 eval_done_q, eval_done_n;
  logic [BCD_W-1:0]     live_bcd_q, live_bcd_n;
  logic [SCORE_W-1:0]   last_score_q, last_score_n;
  logic [BCD_W-1:0]     hi_bcd_q, hi_bcd_n;
  logic [SCORE_W-1:0]   high_score_q, high_score_n;
  logic                 new_record_q, new_record_n;

  logic [BCD_W-1:0]     digits_q, digits_n;
  logic                 seg_en_q, seg_en_n;
  logic                 busy_q, busy_n;

  logic [SCORE_W-1:0]   sat_score_c;
  logic [SCORE_W-1:0]   start_val_c;
  logic                 start_c;

  // Add-3 correction on every BCD nibble of 5 or more before the next shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_n       = state_q;
    hold_cnt_n    = hold_cnt_q;
    blink_cnt_n   = blink_cnt_q;
    blink_n       = blink_q;
    conv_active_n = conv_active_q;
    conv_cnt_n    = conv_cnt_q;
    conv_bin_n    = conv_bin_q;
    conv_bcd_n    = conv_bcd_q;
    conv_val_n    = conv_val_q;
    pend_valid_n  = pend_valid_q;
    pend_val_n    = pend_val_q;
    go_pend_n     = go_pend_q;
    eval_done_n   = 1'b0;
    live_bcd_n    = live_bcd_q;
    last_score_n  = last_score_q;
    hi_bcd_n      = hi_bcd_q;
    high_score_n  = high_score_q;
    new_record_n  = new_record_q;
    digits_n      = live_bcd_q;
    seg_en_n      = 1'b0;
    busy_n        = 1'b0;
    start_c       = 1'b0;
    sat_score_c   = (bus.Score > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : bus.Score;
    start_val_c   = sat_score_c;

    // Conversion engine: load, SCORE_W shift steps, then commit on the next edge.
    if (conv_active_q) begin
      if (conv_cnt_q != CNT_W'(SCORE_W)) begin
        {conv_bcd_n, conv_bin_n} = (BCD_W + SCORE_W)'({dd_adjust(conv_bcd_q), conv_bin_q} << 1);
        conv_cnt_n = conv_cnt_q + CNT_W'(1);
        if (bus.ScoreValid) begin
          pend_valid_n = 1'b1;
          pend_val_n   = sat_score_c;
        end
      end else begin
        live_bcd_n    = conv_bcd_q;
        last_score_n  = conv_val_q;
        conv_active_n = 1'b0;
        // A pulse on the commit edge is newer than anything pending.
        if (bus.ScoreValid || pend_valid_q) begin
          start_c      = 1'b1;
          start_val_c  = bus.ScoreValid ? sat_score_c : pend_val_q;
          pend_valid_n = 1'b0;
        end
      end
    end else if (bus.ScoreValid) begin
      start_c = 1'b1;
    end

    if (start_c) begin
      conv_active_n = 1'b1;
      conv_cnt_n    = '0;
      conv_bin_n    = start_val_c;
      conv_bcd_n    = '0;
      conv_val_n    = start_val_c;
    end

    // High-score evaluation waits until the engine is fully idle.
    if (go_pend_q && !conv_active_q) begin
      go_pend_n   = 1'b0;
      eval_done_n = 1'b1;
      if (last_score_q > high_score_q) begin
        high_score_n = last_score_q;
        hi_bcd_n     = live_bcd_q;
        new_record_n = 1'b1;
      end
    end
    if (bus.GameOver) go_pend_n = 1'b1;

    // Page sequencing.
    unique case (state_q)
      PG_LIVE:    if (eval_done_q) state_n = PG_BANNER;
      PG_BANNER:  if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) state_n = PG_HISCORE;
      PG_HISCORE: if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) state_n = PG_LAST;
      PG_LAST:    if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) state_n = PG_BANNER;
      default:    state_n = PG_LIVE;
    endcase

    // New game wins over everything else arriving in the same cycle.
    if (bus.GameStart) begin
      state_n      = PG_LIVE;
      live_bcd_n   = '0;
      last_score_n = '0;
      new_record_n = 1'b0;
      go_pend_n    = 1'b0;
      eval_done_n  = 1'b0;
      high_score_n = high_score_q;
      hi_bcd_n     = hi_bcd_q;
    end

    if (state_n != state_q) begin
      hold_cnt_n = '0;
    end else if (state_q != PG_LIVE) begin
      hold_cnt_n = hold_cnt_q + HOLD_W'(1);
    end

    // Blink phase restarts high on every HISCORE entry.
    if (state_n == PG_HISCORE && state_q != PG_HISCORE) begin
      blink_n     = 1'b1;
      blink_cnt_n = '0;
    end else if (state_q == PG_HISCORE) begin
      if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
        blink_n     = ~blink_q;
        blink_cnt_n = '0;
      end else begin
        blink_cnt_n = blink_cnt_q + BLINK_W'(1);
      end
    end

    unique case (state_n)
      PG_BANNER:  digits_n = {LETTER_H, LETTER_I, LETTER_G, LETTER_H};
      PG_HISCORE: digits_n = hi_bcd_n;
      default:    digits_n = live_bcd_n;
    endcase

    seg_en_n = bus.DispEn & ((state_n == PG_HISCORE && new_record_n) ? blink_n : 1'b1);
    busy_n   = conv_active_n && (conv_cnt_n != '0);
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q       <= PG_LIVE;
      hold_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
      conv_active_q <= 1'b0;
      conv_cnt_q    <= '0;
      conv_bin_q    <= '0;
      conv_bcd_q    <= '0;
      conv_val_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_val_q    <= '0;
      go_pend_q     <= 1'b0;
      eval_done_q   <= 1'b0;
      live_bcd_q    <= '0;
      last_score_q  <= '0;
      hi_bcd_q      <= '0;
      high_score_q  <= '0;
      new_record_q  <= 1'b0;
      digits_q      <= '0;
      seg_en_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_n;
      hold_cnt_q    <= hold_cnt_n;
      blink_cnt_q   <= blink_cnt_n;
      blink_q       <= blink_n;
      conv_active_q <= conv_active_n;
      conv_cnt_q    <= conv_cnt_n;
      conv_bin_q    <= conv_bin_n;
      conv_bcd_q    <= conv_bcd_n;
      conv_val_q    <= conv_val_n;
      pend_valid_q  <= pend_valid_n;
      pend_val_q    <= pend_val_n;
      go_pend_q     <= go_pend_n;
      eval_done_q   <= eval_done_n;
      live_bcd_q    <= live_bcd_n;
      last_score_q  <= last_score_n;
      hi_bcd_q      <= hi_bcd_n;
      high_score_q  <= high_score_n;
      new_record_q  <= new_record_n;
      digits_q      <= digits_n;
      seg_en_q      <= seg_en_n;
      busy_q        <= busy_n;
    end
  end

  assign bus.FirstDigit  = digits_q[15:12];
  assign bus.SecondDigit = digits_q[11:8];
  assign bus.ThirdDigit  = digits_q[7:4];
  assign bus.FourthDigit = digits_q[3:0];
  assign bus.SegEn       = seg_en_q;
  assign bus.Busy        = busy_q;
  assign bus.HighScore   = high_score_q;

endmodule

// File: tb/tb_score_display_sequencer.sv
// Bench for score_display_sequencer: directed scenarios with literal
// expectations plus random traffic checked cycle by cycle against a timeline model.
module tb_score_display_sequencer;

  localparam int unsigned SCORE_W = 14;
  localparam int unsigned HOLD    = 8;
  localparam int unsigned BLINK   = 2;
  localparam logic [3:0]  LH      = 4'hA;
  localparam logic [3:0]  LI      = 4'hB;
  localparam logic [3:0]  LG      = 4'hC;
  localparam logic [15:0] BANNER  = {LH, LI, LG, LH};

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;

  score_display_sequencer_if #(.SCORE_W(SCORE_W)) bus ();

  score_display_sequencer #(
    .SCORE_W(SCORE_W), .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK),
    .LETTER_H(LH), .LETTER_I(LI), .LETTER_G(LG)
  ) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: conversions as start/finish timestamps, pages as time since rotation start.
  int cyc;
  bit m_conv_on;
  int m_conv_val, m_conv_start, m_conv_end;
  bit m_pend_on;
  int m_pend_val;
  int m_live, m_last, m_high, m_hi_disp;
  bit m_newrec, m_go_pend, m_eval_prev, m_rot_on, m_de;
  int m_rot_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dig();
    return {bus.FirstDigit, bus.SecondDigit, bus.ThirdDigit, bus.FourthDigit};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    cyc = 0; m_conv_on = 0; m_conv_val = 0; m_conv_start = 0; m_conv_end = 0;
    m_pend_on = 0; m_pend_val = 0; m_live = 0; m_last = 0; m_high = 0; m_hi_disp = 0;
    m_newrec = 0; m_go_pend = 0; m_eval_prev = 0; m_rot_on = 0; m_de = 0; m_rot_start = 0;
  endtask

  task automatic model_start(input int v);
    m_conv_on = 1; m_conv_val = v; m_conv_start = cyc; m_conv_end = cyc + SCORE_W + 1;
  endtask

  task automatic model_step();
    bit sv, go, gs, do_eval;
    int sval;
    if (!ResetN) begin
      model_reset();
      return;
    end
    cyc++;
    sv = bus.ScoreValid; go = bus.GameOver; gs = bus.GameStart;
    sval = (int'(bus.Score) > 9999) ? 9999 : int'(bus.Score);
    do_eval = m_go_pend && !m_conv_on && !gs;
    if (!m_rot_on && m_eval_prev && !gs) begin
      m_rot_on = 1;
      m_rot_start = cyc;
    end
    m_eval_prev = do_eval;
    if (do_eval) begin
      m_go_pend = 0;
      if (m_last > m_high) begin
        m_high = m_last; m_hi_disp = m_last; m_newrec = 1;
      end
    end
    if (gs) m_go_pend = 0;
    else if (go) m_go_pend = 1;
    if (m_conv_on && cyc == m_conv_end) begin
      m_live = m_conv_val; m_last = m_conv_val; m_conv_on = 0;
      if (sv) model_start(sval);
      else if (m_pend_on) model_start(m_pend_val);
      m_pend_on = 0;
    end else if (m_conv_on) begin
      if (sv) begin m_pend_on = 1; m_pend_val = sval; end
    end else if (sv) begin
      model_start(sval);
    end
    if (gs) begin
      m_live = 0; m_last = 0; m_newrec = 0; m_rot_on = 0;
    end
    m_de = bus.DispEn;
  endtask

  task automatic compare_all();
    int page, k;
    bit blink, exp_seg;
    logic [15:0] exp_dig;
    page = 0; k = 0;
    if (m_rot_on) begin
      k = (cyc - m_rot_start) / HOLD;
      page = 1 + (k % 3);
    end
    case (page)
      1:       exp_dig = BANNER;
      2:       exp_dig = to_bcd(m_hi_disp);
      default: exp_dig = to_bcd(m_live);
    endcase
    blink = (page == 2) ? (((cyc - (m_rot_start + k * HOLD)) / BLINK) % 2 == 0) : 1'b1;
    exp_seg = m_de && (!(page == 2 && m_newrec) || blink);
    check("model_digits", 32'(dig()), 32'(exp_dig));
    check("model_segen", 32'(bus.SegEn), 32'(exp_seg));
    check("model_busy", 32'(bus.Busy), 32'(m_conv_on && cyc != m_conv_start));
    check("model_high", 32'(bus.HighScore), 32'(m_high));
  endtask

  initial forever begin
    @(posedge Clock);
    model_step();
  end

  initial forever begin
    @(negedge Clock);
    if (chk_en) compare_all();
  end

  task automatic sv_pulse(input int v);
    bus.Score = SCORE_W'(v); bus.ScoreValid = 1'b1;
    @(negedge Clock);
    bus.ScoreValid = 1'b0;
  endtask

  task automatic go_pulse(input bit go, input bit gs);
    bus.GameOver = go; bus.GameStart = gs;
    @(negedge Clock);
    bus.GameOver = 1'b0; bus.GameStart = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    logic [15:0] d14, d15, d29, d30;
    logic [7:0]  seg_hs, seg_last;
    int bc;
    bit saw58;
    bus.Score = '0; bus.ScoreValid = 1'b0; bus.GameOver = 1'b0;
    bus.GameStart = 1'b0; bus.DispEn = 1'b1;
    model_reset();

    // Reset held with ScoreValid pulsing
    bus.Score = SCORE_W'(1234);
    @(negedge Clock);
    chk_en = 1'b1;
    repeat (3) begin
      bus.ScoreValid = ~bus.ScoreValid;
      @(negedge Clock);
    end
    check("rst_digits", 32'(dig()), 32'h0);
    check("rst_segen", 32'(bus.SegEn), 32'h0);
    check("rst_busy", 32'(bus.Busy), 32'h0);
    check("rst_high", 32'(bus.HighScore), 32'h0);
    bus.ScoreValid = 1'b0;
    ResetN = 1'b1;
    wait_cyc(20);
    check("rst_noconv", 32'(dig()), 32'h0);

    // Single conversion latency
    sv_pulse(1234);
    bc = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge Clock);
      if (bus.Busy) bc++;
      if (i == 14) check("pre_1234", 32'(dig()), 32'h0);
    end
    check("busy_len", 32'(bc), 32'd14);
    check("d1234", 32'(dig()), 32'h1234);
    sv_pulse(12000);
    wait_cyc(15);
    check("sat9999", 32'(dig()), 32'h9999);

    // Back-to-back captures
    saw58 = 1'b0; d14 = '0; d15 = '0; d29 = '0; d30 = '0;
    for (int k = 0; k <= 31; k++) begin
      bus.ScoreValid = (k == 0 || k == 3 || k == 5);
      bus.Score = (k == 0) ? SCORE_W'(37) : (k == 3) ? SCORE_W'(58) : SCORE_W'(905);
      @(negedge Clock);
      bus.ScoreValid = 1'b0;
      if (dig() == 16'h0058) saw58 = 1'b1;
      if (k == 14) d14 = dig();
      if (k == 15) d15 = dig();
      if (k == 29) d29 = dig();
      if (k == 30) d30 = dig();
    end
    check("b2b_t14", 32'(d14), 32'h9999);
    check("b2b_t15", 32'(d15), 32'h0037);
    check("b2b_t29", 32'(d29), 32'h0037);
    check("b2b_t30", 32'(d30), 32'h0905);
    check("b2b_no58", 32'(saw58), 32'h0);

    // Establish HighScore=500
    sv_pulse(500); wait_cyc(15);
    go_pulse(1, 0); wait_cyc(2);
    check("high500", 32'(bus.HighScore), 32'd500);
    go_pulse(0, 1);
    check("gs_live0", 32'(dig()), 32'h0);

    // New record 731
    sv_pulse(731); wait_cyc(15);
    go_pulse(1, 0);
    seg_hs = '0; seg_last = '0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge Clock);
      if (k == 1) check("rec_high_t1", 32'(bus.HighScore), 32'd731);
      if (k == 1) check("rec_live_t1", 32'(dig()), 32'h0731);
      if (k == 2) check("rec_banner_t2", 32'(dig()), 32'(BANNER));
      if (k == 9) check("rec_banner_t9", 32'(dig()), 32'(BANNER));
      if (k == 10) check("rec_hiscore", 32'(dig()), 32'h0731);
      if (k >= 10 && k <= 17) seg_hs[k-10] = bus.SegEn;
      if (k == 18) check("rec_last", 32'(dig()), 32'h0731);
      if (k >= 18 && k <= 25) seg_last[k-18] = bus.SegEn;
      if (k == 26) check("rec_banner_again", 32'(dig()), 32'(BANNER));
    end
    check("rec_blink", 32'(seg_hs), 32'h33);
    check("rec_last_seg", 32'(seg_last), 32'hFF);

    // Tie with the high score
    go_pulse(0, 1);
    sv_pulse(731); wait_cyc(15);
    go_pulse(1, 0);
    seg_hs = '0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge Clock);
      if (k == 10) check("tie_hiscore", 32'(dig()), 32'h0731);
      if (k >= 10) seg_hs[k-10] = bus.SegEn;
    end
    check("tie_seg_steady", 32'(seg_hs), 32'hFF);
    check("tie_high", 32'(bus.HighScore), 32'd731);

    // Simultaneous ScoreValid and GameOver with HighScore=100
    ResetN = 1'b0; wait_cyc(2); ResetN = 1'b1;
    sv_pulse(100); wait_cyc(15);
    go_pulse(1, 0); wait_cyc(3);
    check("high100", 32'(bus.HighScore), 32'd100);
    go_pulse(0, 1);
    bus.Score = SCORE_W'(200); bus.ScoreValid = 1'b1; bus.GameOver = 1'b1;
    @(negedge Clock);
    bus.ScoreValid = 1'b0; bus.GameOver = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge Clock);
      if (k == 15) check("sim_high_t15", 32'(bus.HighScore), 32'd100);
      if (k == 16) check("sim_high_t16", 32'(bus.HighScore), 32'd200);
      if (k == 16) check("sim_live_t16", 32'(dig()), 32'h0200);
      if (k == 17) check("sim_banner_t17", 32'(dig()), 32'(BANNER));
    end
    go_pulse(1, 1);
    check("gs_go_live", 32'(dig()), 32'h0);
    wait_cyc(4);
    check("gs_go_stay", 32'(dig()), 32'h0);
    check("gs_go_high", 32'(bus.HighScore), 32'd200);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.ScoreValid = ($urandom_range(0, 29) == 0);
      bus.Score      = SCORE_W'($urandom_range(0, 16383));
      bus.GameOver   = ($urandom_range(0, 39) == 0);
      bus.GameStart  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) bus.DispEn = ~bus.DispEn;
      ResetN = ($urandom_range(0, 999) != 0);
      @(negedge Clock);
    end
    bus.ScoreValid = 1'b0; bus.GameOver = 1'b0; bus.GameStart = 1'b0; ResetN = 1'b1;
    wait_cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_display_sequencer.md
# score_display_sequencer

Sequences what the four-digit seven-segment display shows during and after a game. Converts the binary score to BCD with an iterative double-dabble engine and tracks the high score. After game over it rotates between a "HIGH" banner, the high score and the last score. Drives the digit and enable inputs of the display scanner; the scanner itself is unchanged.

## Interface
- SCORE_W, 14, width of the binary score input; the score saturates at 9999.
- HOLD_CYCLES, 50_000_000, Clock cycles each page is held in the post-game rotation.
- BLINK_CYCLES, 12_500_000, half-period of the new-record blink.
- Clock  in  1  system clock; all logic is on its rising edge.
- ResetN  in  1  synchronous, active-low reset.
- Score  in  SCORE_W  binary score.
- ScoreValid  in  1  one-cycle pulse that latches Score.
- GameOver  in  1  one-cycle pulse at the end of a game.
- GameStart  in  1  one-cycle pulse at the start of a game.
- DispEn  in  1  global display enable.
- FirstDigit, SecondDigit, ThirdDigit, FourthDigit  out  4 each  digit codes: 0–9 or the `LETTER_H`/`LETTER_I`/`LETTER_G` codes. FirstDigit is the most significant digit.
- SegEn  out  1  enable to the scanner.
- Busy  out  1  a conversion is in progress.
- HighScore  out  SCORE_W  binary high score.

## Operation
- **Capture:** on ScoreValid with Busy=0, latch min(Score, 9999) and start a conversion.
  - If Busy=1, store the value in a one-deep pending register. A newer pulse overwrites the pending value.
  - The pending value starts converting on the cycle after the current conversion completes.
- **Conversion:** double-dabble, one shift-plus-add-3 step per cycle, SCORE_W steps.
  - On completion, load the result into the live BCD register and the last-score binary register.
- **High score:** evaluated on GameOver after any in-flight and pending conversions finish. A deferred-GameOver flag handles this case.
  - If last score > HighScore, copy the binary value and BCD value into the high-score registers and set NewRecord.
  - An equal score does not set NewRecord.
- **Page FSM states:**
  - LIVE: digits = live BCD.
  - BANNER: digits = H, I, G, H.
  - HISCORE: digits = high-score BCD.
  - LAST: digits = live BCD.
- **Page FSM transitions:**
  - ResetN=0 forces LIVE.
  - LIVE goes to BANNER once the GameOver evaluation completes.
  - After that, BANNER → HISCORE → LAST → BANNER, each page held HOLD_CYCLES cycles. The hold counter restarts on every page entry.
  - GameStart in any state goes to LIVE on the next edge, zeroes the live BCD and last score, and clears NewRecord. The high score is retained.
  - GameStart and GameOver in the same cycle: GameStart wins and GameOver is dropped.
- **SegEn:**
  - In HISCORE with NewRecord=1: SegEn = DispEn AND blink phase. The blink phase toggles every BLINK_CYCLES and resets to 1 on HISCORE entry.
  - Otherwise: SegEn = DispEn.
- Scores with fewer than four digits show leading zeros.

## Timing
- All outputs are registered.
- Reset values:
  - All digits 0.
  - SegEn 0.
  - Busy 0.
  - HighScore 0, high-score BCD 0, live BCD 0.
  - NewRecord 0, pending register empty, state LIVE, counters 0.
- Reset during a conversion aborts it; the pending value and the deferred GameOver are discarded.
- Conversion latency:
  - ScoreValid sampled at edge t.
  - Busy=1 from t+1 through t+SCORE_W.
  - Digits and last score are updated at edge t+SCORE_W+1, and Busy=0 at that edge.
- GameOver sampled at edge t with Busy=0 and nothing pending:
  - HighScore and NewRecord are updated at t+1.
  - The state is BANNER at t+2.
  - Digits show H I G H from t+2.
- Page outputs change on the same edge as the state transition.
- SegEn follows DispEn with a one-cycle delay.
- ScoreValid in BANNER, HISCORE or LAST converts normally; LAST shows the new value.

## Test plan
HOLD_CYCLES=8 and BLINK_CYCLES=2 for all scenarios.
- **Reset:** hold ResetN=0 for 3 cycles with ScoreValid pulsing → digits 0,0,0,0; SegEn=0; Busy=0; HighScore=0; nothing converts.
- **Single conversion:** Score=1234 pulsed at t → Busy=1 for exactly 14 cycles; digits 1,2,3,4 at t+15. Score=12000 → 9,9,9,9.
- **Back-to-back captures:** pulses with 37, then 58 at t+3, then 905 at t+5 → 37 displayed at t+15; 905 displayed at t+30; 58 is never displayed.
- **New record:** HighScore=500, score 731, then GameOver → HighScore=731 at t+1; H,I,G,H for 8 cycles; 0,7,3,1 with SegEn toggling every 2 cycles for 8 cycles; then LAST 0,7,3,1 steady; then BANNER again.
- **Tie:** score 731 with HighScore=731, GameOver → NewRecord=0; HISCORE page shows SegEn steady 1.
- **Simultaneous events:** ScoreValid(200) and GameOver in the same cycle with HighScore=100 → BANNER entered only after the conversion completes; HighScore=200. GameStart together with GameOver → LIVE with 0,0,0,0; HighScore unchanged.
